pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipeline. Drives the per-stage latch enable/flush signals, PC enable and PC mux select.
- Arbitrates between instruction-fetch stalls, data-memory stalls, load-use hazards, taken branches/jumps and halt draining.
- Sits beside the datapath and replaces the purely combinational hazard decode with a small FSM plus a halt latch.

Parameters:
- REG_W, 5, register index width.
- DRAIN_CYCLES, 3, cycles after halt reaches MEM before halted asserts (empties EX_MEM/MEM_WB).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- mem_dREN  in  1  MEM-stage instruction is a load.
- mem_dWEN  in  1  MEM-stage instruction is a store.
- ex_load  in  1  EX-stage instruction is a load.
- ex_rt  in  REG_W  destination register of EX-stage load.
- id_rs  in  REG_W  ID-stage source register rs.
- id_rt  in  REG_W  ID-stage source register rt.
- id_uses_rt  in  1  ID-stage instruction reads rt.
- ex_branch_taken  in  1  branch resolved taken in EX.
- id_jump  in  1  J/JAL decoded in ID.
- id_jr  in  1  JR decoded in ID.
- mem_halt  in  1  HALT is in MEM stage.
- enable_pc  out  1  PC register load.
- PCSrc  out  2  pc_mux_input_selection encoding: 0 PC+4, 1 branch, 2 jump, 3 jr.
- enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB  out  1 each  latch enables.
- flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  out  1 each  synchronous bubble insert (applies only when the matching enable=1).
- halted  out  1  registered; core fully stopped.
- stall_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- nRST low (async): state=RUN, halted=0, drain counter=0, stall_cycles=0.
  - During reset all enables=0, flushes=0, PCSrc=0.
- Outputs are a combinational decode of state and inputs; only state, drain counter, halted and stall_cycles are registered.
- States: RUN, DWAIT, DRAIN, HALTED.
- Priority within one cycle, highest first: halt > dmem stall > load-use > EX branch > ID jump/jr > imem stall.
- dmem stall:
  - Condition: (mem_dREN|mem_dWEN)&!dhit.
  - Action: enable_pc, IF_ID, ID_EX, EX_MEM = 0; enable_MEM_WB=1 with flush_MEM_WB=1.
  - RUN->DWAIT. DWAIT stays until dhit, then returns to RUN in the same cycle the dhit-completing advance happens (all enables=1).
- Load-use:
  - Condition: ex_load & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
  - Action: enable_pc=0, enable_IF_ID=0, flush_ID_EX=1, remaining enables=1.
  - Exactly one bubble per hazard. Remains in RUN.
- EX branch taken (requires ihit):
  - PCSrc=1, enable_pc=1, flush_IF_ID=1, flush_ID_EX=1.
  - Overrides any simultaneous ID jump.
- ID jump/jr (requires ihit):
  - PCSrc=2 or 3, enable_pc=1, flush_IF_ID=1.
  - jr with a load-use hazard on rs: load-use wins; the jump is taken next cycle.
- imem stall (!ihit, no higher event):
  - enable_pc=0, enable_IF_ID=0, flush_ID_EX=1; EX_MEM and MEM_WB advance.
- Register 0 never produces a load-use stall.
- Halt:
  - mem_halt in RUN/DWAIT (once dhit is satisfied) -> DRAIN.
  - enable_pc=0, flush_IF_ID, flush_ID_EX, flush_EX_MEM = 1 with enables=1.
  - Counter counts DRAIN_CYCLES cycles, then HALTED.
- HALTED: halted=1, all enables=0, flushes=0. Sticky until reset.
- Reset asserted mid-DWAIT or mid-DRAIN returns to RUN immediately; no partial state is kept.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: stall_cycles increments (wrapping at 2^32) on every cycle in RUN/DWAIT where enable_pc=0 for a reason other than halt. Cleared by reset and frozen in DRAIN/HALTED.
- Undefined: no counter logic; stall_cycles tied to 0.

Test Plan:
- Reset release with ihit=1 and no hazards -> every cycle all enables=1, flushes=0, PCSrc=0, halted=0.
- Load-use: ex_load=1, ex_rt=5, id_rs=5 for one cycle -> enable_pc=0, enable_IF_ID=0, flush_ID_EX=1 for exactly 1 cycle. Repeat with ex_rt=0 -> no stall.
- dmem stall: mem_dREN=1, dhit=0 for 3 cycles then 1 -> state DWAIT for 3 cycles, flush_MEM_WB=1 each cycle, then all enables=1. stall_cycles=3 with HAZARD_STALL_CNT_EN.
- Same cycle: ex_branch_taken=1, id_jump=1 -> PCSrc=1, flush_IF_ID=1, flush_ID_EX=1.
- mem_halt=1 with DRAIN_CYCLES=3 -> enable_pc=0 immediately; halted=1 on the 4th edge and stays 1 with further ihit toggling; nRST low -> halted=0 asynchronously.
- ihit=0 with no other event -> enable_pc=0, enable_IF_ID=0, flush_ID_EX=1, enable_EX_MEM=1, enable_MEM_WB=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencing controller for the 5-stage pipeline: stage enables/flushes, PC control, halt drain.
// Define HAZARD_STALL_CNT_EN to build the stall_cycles performance counter (tied to 0 otherwise).
//
// state  | meaning
// RUN    | normal issue; combinational hazard priority decode
// DWAIT  | data access outstanding; front of pipe frozen, bubbles into MEM_WB
// DRAIN  | halt seen in MEM; flushing younger stages for DRAIN_CYCLES cycles
// HALTED | core stopped; everything frozen until reset
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             mem_halt,
  output logic             enable_pc,
  output logic [1:0]       PCSrc,
  output logic             enable_IF_ID,
  output logic             enable_ID_EX,
  output logic             enable_EX_MEM,
  output logic             enable_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             flush_MEM_WB,
  output logic             halted,
  output logic [31:0]      stall_cycles
);

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] drain_cnt;
  logic             halt_evt;
  logic             dstall;
  logic             load_use;

  assign dstall   = (mem_dREN | mem_dWEN) & ~dhit;
  assign load_use = ex_load & (ex_rt != '0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      state <= next_state;
      if (halt_evt)
        drain_cnt <= DRAIN_LOAD;
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 1'b1;
      halted <= halted | (state == DRAIN && drain_cnt == '0);
    end
  end

  always_comb begin
    next_state    = state;
    halt_evt      = 1'b0;
    enable_pc     = 1'b0;
    PCSrc         = 2'd0;
    enable_IF_ID  = 1'b0;
    enable_ID_EX  = 1'b0;
    enable_EX_MEM = 1'b0;
    enable_MEM_WB = 1'b0;
    flush_IF_ID   = 1'b0;
    flush_ID_EX   = 1'b0;
    flush_EX_MEM  = 1'b0;
    flush_MEM_WB  = 1'b0;
    // Outputs are forced quiet while reset is held, independent of state.
    if (nRST) begin
      case (state)
        RUN, DWAIT: begin
          if (mem_halt && !(state == DWAIT && dstall)) begin
            halt_evt      = 1'b1;
            next_state    = DRAIN;
            enable_IF_ID  = 1'b1;
            enable_ID_EX  = 1'b1;
            enable_EX_MEM = 1'b1;
            enable_MEM_WB = 1'b1;
            flush_IF_ID   = 1'b1;
            flush_ID_EX   = 1'b1;
            flush_EX_MEM  = 1'b1;
          end else if (dstall) begin
            next_state    = DWAIT;
            enable_MEM_WB = 1'b1;
            flush_MEM_WB  = 1'b1;
          end else begin
            next_state    = RUN;
            enable_pc     = 1'b1;
            enable_IF_ID  = 1'b1;
            enable_ID_EX  = 1'b1;
            enable_EX_MEM = 1'b1;
            enable_MEM_WB = 1'b1;
            if (load_use) begin
              enable_pc    = 1'b0;
              enable_IF_ID = 1'b0;
              flush_ID_EX  = 1'b1;
            end else if (ex_branch_taken && ihit) begin
              PCSrc       = 2'd1;
              flush_IF_ID = 1'b1;
              flush_ID_EX = 1'b1;
            end else if ((id_jump || id_jr) && ihit) begin
              PCSrc       = id_jump ? 2'd2 : 2'd3;
              flush_IF_ID = 1'b1;
            end else if (!ihit) begin
              enable_pc    = 1'b0;
              enable_IF_ID = 1'b0;
              flush_ID_EX  = 1'b1;
            end
          end
        end
        DRAIN: begin
          enable_IF_ID  = 1'b1;
          enable_ID_EX  = 1'b1;
          enable_EX_MEM = 1'b1;
          enable_MEM_WB = 1'b1;
          flush_IF_ID   = 1'b1;
          flush_ID_EX   = 1'b1;
          flush_EX_MEM  = 1'b1;
          if (drain_cnt == '0)
            next_state = HALTED;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Halt-induced PC holds are excluded; DRAIN/HALTED never count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stall_cnt <= '0;
    else if ((state == RUN || state == DWAIT) && !enable_pc && !halt_evt)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expected control vectors are hand-computed constants.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, mem_dREN, mem_dWEN, ex_load, id_uses_rt;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       ex_branch_taken, id_jump, id_jr, mem_halt;
  logic       enable_pc;
  logic [1:0] PCSrc;
  logic       enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB;
  logic       flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
  logic       halted;
  logic [31:0] stall_cycles;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  // {enable_pc, PCSrc, en IF/ID/EX/MEM, flush IF/ID/EX/MEM, halted}
  localparam logic [11:0] V_RST = 12'b0;
  localparam logic [11:0] V_RUN = {1'b1, 2'd0, 4'b1111, 4'b0000, 1'b0};
  localparam logic [11:0] V_LU  = {1'b0, 2'd0, 4'b0111, 4'b0100, 1'b0};
  localparam logic [11:0] V_DM  = {1'b0, 2'd0, 4'b0001, 4'b0001, 1'b0};
  localparam logic [11:0] V_BR  = {1'b1, 2'd1, 4'b1111, 4'b1100, 1'b0};
  localparam logic [11:0] V_J   = {1'b1, 2'd2, 4'b1111, 4'b1000, 1'b0};
  localparam logic [11:0] V_JR  = {1'b1, 2'd3, 4'b1111, 4'b1000, 1'b0};
  localparam logic [11:0] V_DR  = {1'b0, 2'd0, 4'b1111, 4'b1110, 1'b0};
  localparam logic [11:0] V_HL  = {1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1};

  logic [11:0] obs;
  assign obs = {enable_pc, PCSrc, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
                flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halted};

  pipeline_hazard_ctrl #(.REG_W(5), .DRAIN_CYCLES(3)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_load(ex_load),
    .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .id_jr(id_jr),
    .mem_halt(mem_halt), .enable_pc(enable_pc), .PCSrc(PCSrc),
    .enable_IF_ID(enable_IF_ID), .enable_ID_EX(enable_ID_EX),
    .enable_EX_MEM(enable_EX_MEM), .enable_MEM_WB(enable_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk_cnt(input string tag, input int n);
    chk(tag, stall_cycles, CNT_ON ? n : 0);
  endtask

  task automatic idle();
    ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0; ex_load = 0; id_uses_rt = 0;
    ex_rt = 5'd1; id_rs = 5'd2; id_rt = 5'd3;
    ex_branch_taken = 0; id_jump = 0; id_jr = 0; mem_halt = 0;
  endtask

  // Inputs change at the falling edge; outputs are sampled 2 time units later.
  task automatic next_cycle();
    @(negedge CLK);
    idle();
  endtask

  initial begin
    nRST = 0;
    idle();
    #2;
    chk("reset_outputs", obs, V_RST);
    chk_cnt("reset_count", 0);

    @(negedge CLK);
    nRST = 1;
    #2 chk("run_0", obs, V_RUN);
    for (int i = 1; i < 3; i++) begin
      next_cycle();
      #2 chk("run_n", obs, V_RUN);
    end

    next_cycle(); ex_load = 1; ex_rt = 5'd5; id_rs = 5'd5;
    #2 chk("load_use_rs", obs, V_LU);
    next_cycle();
    #2 chk("load_use_one_bubble", obs, V_RUN);
    chk_cnt("count_after_lu", 1);

    next_cycle(); ex_load = 1; ex_rt = 5'd0; id_rs = 5'd0;
    #2 chk("load_use_r0", obs, V_RUN);
    next_cycle(); ex_load = 1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1;
    #2 chk("load_use_rt", obs, V_LU);
    next_cycle(); ex_load = 1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 0;
    #2 chk("load_use_rt_unused", obs, V_RUN);

    for (int i = 0; i < 3; i++) begin
      next_cycle(); mem_dREN = 1; dhit = 0;
      #2 chk("dmem_stall", obs, V_DM);
    end
    next_cycle(); mem_dREN = 1; dhit = 1;
    #2 chk("dmem_release", obs, V_RUN);
    next_cycle();
    #2 chk("after_dmem", obs, V_RUN);
    chk_cnt("count_after_dmem", 5);

    next_cycle(); ex_branch_taken = 1; id_jump = 1;
    #2 chk("branch_over_jump", obs, V_BR);
    next_cycle(); id_jump = 1;
    #2 chk("jump", obs, V_J);
    next_cycle(); id_jr = 1;
    #2 chk("jr", obs, V_JR);
    next_cycle(); ex_branch_taken = 1; ihit = 0;
    #2 chk("branch_no_ihit", obs, V_LU);

    next_cycle(); id_jr = 1; ex_load = 1; ex_rt = 5'd9; id_rs = 5'd9;
    #2 chk("jr_load_use", obs, V_LU);
    next_cycle(); id_jr = 1; id_rs = 5'd9;
    #2 chk("jr_after_bubble", obs, V_JR);

    next_cycle(); ihit = 0;
    #2 chk("imem_stall", obs, V_LU);
    next_cycle();
    #2 chk("after_imem", obs, V_RUN);
    chk_cnt("count_before_halt", 8);

    next_cycle(); mem_halt = 1;
    #2 chk("halt_seen", obs, V_DR);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #2 chk("draining", obs, V_DR);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle(); ihit = i[0]; mem_dREN = 1; id_jump = 1;
      #2 chk("halted_sticky", obs, V_HL);
    end
    chk_cnt("count_frozen_halt", 8);

    nRST = 0;
    #1 chk("async_reset_halted", obs, V_RST);
    chk_cnt("async_reset_count", 0);
    next_cycle(); nRST = 1;
    #2 chk("run_after_reset", obs, V_RUN);

    next_cycle(); mem_halt = 1;
    #2 chk("halt_again", obs, V_DR);
    next_cycle();
    #2 chk("drain_again", obs, V_DR);
    nRST = 0;
    #1 chk("reset_mid_drain", obs, V_RST);
    next_cycle(); nRST = 1;
    #2 chk("run_after_drain_reset", obs, V_RUN);
    next_cycle();
    #2 chk("run_stable", obs, V_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
